counter_sched: RTL

//   Scheduler that shares one counter_20bit instance between NREQ requesters.
//   - Arbitration is round-robin.
//   - For the granted requester, it clears the counter, then pulses the counter enable exactly len times at a prescaled rate.
//   - It then signals done to that requester.
//   - Sits between the fuzzy-logic timing clients and the shared counter (drives its rst/en pins).

---
 rtl/counter_sched_pkg.sv | 16 +
 rtl/counter_sched_rr_arbiter.sv | 37 +++
 rtl/counter_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and default widths for the counter scheduler.
// State encodings are fixed because they appear in waveform and debug tooling.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_LEN_W = 8;
    localparam int DEF_PRE_W = 4;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin picker: the first set request after last_owner_i
// wins, so the most recent owner ends up with the lowest priority.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] last_owner_i,
    output logic [NREQ-1:0]         pick_o,
    output logic [$clog2(NREQ)-1:0] idx_o
);

    localparam int IDX_W = $clog2(NREQ);

    logic found;
    int   cand;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        cand   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = int'(last_owner_i) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                pick_o[cand] = 1'b1;
                idx_o        = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Shares one external counter among NREQ requesters: round-robin grant, counter
// clear, len prescaled enable pulses, then a done pulse back to the owner.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int LEN_W = DEF_LEN_W,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*LEN_W-1:0]   len_i,
    input  logic [PRE_W-1:0]        prescale_i,
    input  logic                    abort_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] owner_o,
    output logic                    busy_o,
    output logic                    cnt_clr_o,
    output logic                    cnt_en_o,
    output logic [NREQ-1:0]         done_o
);

    localparam int IDX_W = $clog2(NREQ);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [NREQ-1:0]    owner_oh_q, owner_oh_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [PRE_W-1:0]   pre_lim_q, pre_lim_d;

    logic [NREQ-1:0]    gnt_q, gnt_d, done_q, done_d;
    logic [IDX_W-1:0]   owner_out_q, owner_out_d;
    logic               busy_q, busy_d, cnt_clr_q, cnt_clr_d, cnt_en_q, cnt_en_d;

    logic [NREQ-1:0]    pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_req;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i        (req_i),
        .last_owner_i (last_owner_q),
        .pick_o       (pick),
        .idx_o        (pick_idx)
    );

    assign owner_req = req_i[owner_q];

    // cnt_en_q marks the cycle in which the current pulse is on the pin, so the
    // run bookkeeping advances on it and the next pulse is decided one cycle ahead.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        owner_oh_d   = owner_oh_q;
        remaining_d  = remaining_q;
        pre_cnt_d    = pre_cnt_q;
        pre_lim_d    = pre_lim_q;

        case (state_q)
            ST_IDLE: begin
                pre_cnt_d = '0;
                if (!abort_i && (|req_i)) begin
                    owner_d      = pick_idx;
                    owner_oh_d   = pick;
                    last_owner_d = pick_idx;
                    remaining_d  = len_i[int'(pick_idx)*LEN_W +: LEN_W];
                    pre_lim_d    = prescale_i;
                    state_d      = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                pre_cnt_d = '0;
                if (abort_i || !owner_req) begin
                    state_d = ST_IDLE;
                end else if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_i || !owner_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_en_q) begin
                    pre_cnt_d   = '0;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q + PRE_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        gnt_d       = busy_d ? owner_oh_d : '0;
        owner_out_d = busy_d ? owner_d : '0;
        cnt_clr_d   = (state_d == ST_CLEAR);
        cnt_en_d    = (state_d == ST_RUN) && (pre_cnt_d == pre_lim_d);
        done_d      = (state_d == ST_DONE) ? owner_oh_d : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NREQ - 1);
            owner_oh_q   <= '0;
            remaining_q  <= '0;
            pre_cnt_q    <= '0;
            pre_lim_q    <= '0;
            gnt_q        <= '0;
            owner_out_q  <= '0;
            busy_q       <= 1'b0;
            cnt_clr_q    <= 1'b0;
            cnt_en_q     <= 1'b0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            owner_oh_q   <= owner_oh_d;
            remaining_q  <= remaining_d;
            pre_cnt_q    <= pre_cnt_d;
            pre_lim_q    <= pre_lim_d;
            gnt_q        <= gnt_d;
            owner_out_q  <= owner_out_d;
            busy_q       <= busy_d;
            cnt_clr_q    <= cnt_clr_d;
            cnt_en_q     <= cnt_en_d;
            done_q       <= done_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign owner_o   = owner_out_q;
    assign busy_o    = busy_q;
    assign cnt_clr_o = cnt_clr_q;
    assign cnt_en_o  = cnt_en_q;
    assign done_o    = done_q;

endmodule
